// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver.
// Latches a packed hex word plus decimal points and scans the digits one at
// a time. Supports leading-zero blanking, per-digit blinking and a strobe
// at the start of each scan frame.
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic                  LOAD,
  input  logic                  EN,
  input  logic                  BLANK_LZ,
  input  logic [DIGITS-1:0]     BLINK_MASK,
  output logic [DIGITS-1:0]     AN,
  output logic [7:0]            SEG,
  output logic                  FRAME
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                phase_q, phase_d;
  logic                frame_pend_q, frame_pend_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_q, frame_d;

  logic                prescaler_wrap;
  logic                idx_wrap;
  logic                frame_cnt_wrap;
  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic                cur_blink;
  logic                cur_lz;
  logic [DIGITS-1:0]   lz_mask;
  logic                all_zero;

  // Hex nibble to active-low g..a segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next state of the prescaler, digit index, frame/blink counters and display latch.
  always_comb begin
    prescaler_wrap = (prescaler_q == PRE_MAX);
    idx_wrap       = prescaler_wrap && (idx_q == IDX_MAX);
    frame_cnt_wrap = idx_wrap && (frame_cnt_q == FRM_MAX);

    prescaler_d = prescaler_wrap ? '0 : prescaler_q + PRE_W'(1);

    idx_d = idx_q;
    if (prescaler_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end

    frame_cnt_d = frame_cnt_q;
    if (idx_wrap) begin
      frame_cnt_d = frame_cnt_wrap ? '0 : frame_cnt_q + FRM_W'(1);
    end

    phase_d      = phase_q ^ frame_cnt_wrap;
    frame_pend_d = idx_wrap;
    data_d       = LOAD ? DATA  : data_q;
    dp_d         = LOAD ? DP_IN : dp_q;
  end

  // Select the active digit's latched data and mark digits that are leading zeros.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    cur_lz     = 1'b0;
    lz_mask    = '0;
    all_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero && (data_q[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero && (i != 0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nibble = data_q[4*i +: 4];
        cur_dp     = dp_q[i];
        cur_blink  = BLINK_MASK[i];
        cur_lz     = lz_mask[i];
      end
    end
  end

  // Output pattern for the next cycle: enable, then blink, then blanking, then decode.
  always_comb begin
    an_d    = '1;
    seg_d   = 8'hFF;
    frame_d = frame_pend_q;
    if (EN) begin
      for (int i = 0; i < DIGITS; i++) begin
        an_d[i] = (idx_q != IDX_W'(i));
      end
      if (phase_q && cur_blink) begin
        seg_d = 8'hFF;
      end else if (BLANK_LZ && cur_lz) begin
        seg_d = {~cur_dp, 7'h7F};
      end else begin
        seg_d = {~cur_dp, hex_to_seg(cur_nibble)};
      end
    end
  end

  // State and registered outputs, cleared by synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescaler_q  <= '0;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      phase_q      <= 1'b0;
      frame_pend_q <= 1'b0;
      data_q       <= '0;
      dp_q         <= '0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
      frame_q      <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      frame_pend_q <= frame_pend_d;
      data_q       <= data_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_q      <= frame_d;
    end
  end

  assign AN    = an_q;
  assign SEG   = seg_q;
  assign FRAME = frame_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a parametrised multi-digit common-anode 7-segment display. It latches a packed hexadecimal word with per-digit decimal points and scans it digit by digit at a programmable refresh rate. It adds optional leading-zero blanking, per-digit blinking and a frame-boundary strobe. It sits between the timer/counter datapath and the board display pins and replaces per-digit static decoding.

## Interface
- DIGITS, 4: number of digits scanned, legal range 1..8.
- REFRESH_DIV, 100000: clock cycles each digit stays active, ≥2.
- BLINK_FRAMES, 64: full scan frames per blink half-period, ≥1.

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- DATA  in  4*DIGITS  hex nibbles; nibble i = DATA[4i+3:4i], digit 0 rightmost.
- DP_IN  in  DIGITS  decimal point per digit, 1 = lit.
- LOAD  in  1  when high at a clock edge, DATA/DP_IN are captured into the display latch.
- EN  in  1  0 = display dark (all anodes off), scanning continues.
- BLANK_LZ  in  1  1 = suppress leading zeros.
- BLINK_MASK  in  DIGITS  1 = digit blinks.
- AN  out  DIGITS  anode enables, active-low, one-hot-low while scanning.
- SEG  out  8  active-low segments; SEG[7]=DP, SEG[6:0]=g..a.
- FRAME  out  1  one-cycle pulse at the start of each scan frame.

## Operation
- Display latch (4*DIGITS data + DIGITS dp): cleared by RST, loaded on LOAD. The display shows only latched values, so a slot never tears mid-update.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On wrap, digit index idx advances: idx = (idx==DIGITS-1) ? 0 : idx+1.
- Frame counter counts idx wraps 0..BLINK_FRAMES-1. On its wrap, blink phase toggles: 0 = visible, 1 = hidden.
- Decode of nibble n to SEG[6:0] (hex, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
- SEG[7] = ~dp_latch[idx].
- Leading-zero blank applies to digit i when BLANK_LZ=1, i≠0, and latched nibbles i..DIGITS-1 are all zero. SEG[6:0] becomes 7F; DP is still driven.
- Blink hide applies when phase=1 and BLINK_MASK[idx]=1. SEG becomes FF, DP included. AN is unaffected.
- EN=0 forces AN to all ones and SEG to FF. Counters, latch and FRAME run normally.
- Priority from highest: RST > EN=0 > blink hide > leading-zero blank > decode.
- BLANK_LZ, BLINK_MASK and EN are used live, not latched.

## Timing
- Reset values: AN all ones, SEG=FF, FRAME=0, idx=0, prescaler=0, frame counter=0, phase=0, latch=0.
- AN, SEG and FRAME are registered. They reflect the idx, latch and control inputs from the preceding cycle.
- First edge after RST deasserts: AN = ~(1<<0), SEG = C0 (latch zero, dp off).
- Each digit is active for exactly REFRESH_DIV cycles. A frame lasts DIGITS*REFRESH_DIV cycles.
- FRAME is high for exactly the first cycle AN returns to digit 0 after a wrap. It is not asserted on the first post-reset cycle.
- LOAD: latch updates at edge E. SEG shows the new value from edge E+1, within the currently active slot.
- LOAD held high: the latch re-captures every cycle.
- DIGITS=1: AN constant 0 while enabled. FRAME pulses every REFRESH_DIV cycles.
- RST mid-frame: all state returns to reset values on that edge. Scanning restarts at digit 0.
- Blink phase toggles coincide with a FRAME cycle. The first hidden slot is the digit-0 slot of that frame.

## Test plan
- Config for all tests: DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
- Reset/scan: hold RST 3 cycles, then release.
  - During reset: AN=F, SEG=FF.
  - After release: AN sequence 1110, 1101, 1011, 0111, each for 4 cycles, then 1110 with FRAME=1 for one cycle at cycle 17.
- Decode: LOAD with DATA=16'h1F0A, DP_IN=4'b0100.
  - Required SEG per slot: digit0 = 88, digit1 = C0, digit2 = 0E, digit3 = F9.
- Leading zeros: DATA=16'h0005, BLANK_LZ=1.
  - Required SEG: digit0 = 92, digits 1–3 = FF.
  - DATA=16'h0000 gives digit0 = C0 and digits 1–3 = FF.
  - BLANK_LZ=0 shows C0 on all three upper digits.
- Blink: BLINK_MASK=4'b0001, DATA=16'h1234.
  - Frames 0–1: digit0 SEG = 99.
  - Frames 2–3: digit0 SEG = FF while AN=1110 still asserted.
  - Other digits are unaffected.
- EN/reset mid-operation:
  - EN=0 mid-slot: AN=F and SEG=FF next cycle, and FRAME pulses persist.
  - RST in the slot for digit 2: the next cycle shows reset values, then a restart at AN=1110.
